// File: rtl/sw_pass_sched.sv
// Multi-pass Smith-Waterman scheduler: buffers one query/target pair, streams the
// query through the PE array in PE_LENGTH-sized passes and recirculates the boundary column.
module sw_pass_sched #(
    parameter int Q_LEN      = 256,
    parameter int T_LEN      = 256,
    parameter int PE_LENGTH  = 128,
    parameter int OPEN_SCORE = -7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [1:0]  data_s,
    input  logic [1:0]  data_t,
    output logic        finish,
    output logic [11:0] max,
    output logic        arr_load,
    output logic [1:0]  arr_s,
    output logic        arr_valid,
    output logic [1:0]  arr_t,
    output logic [11:0] arr_v_in,
    output logic [11:0] arr_f_in,
    output logic [11:0] arr_max_in,
    input  logic        arr_valid_out,
    input  logic [11:0] arr_v_out,
    input  logic [11:0] arr_f_out,
    input  logic [11:0] arr_max_out
);

    localparam int PASSES = Q_LEN / PE_LENGTH;
    localparam int QW     = $clog2(Q_LEN);
    localparam int TW     = $clog2(T_LEN);
    localparam int CW     = $clog2(T_LEN + 1);
    localparam int IW     = $clog2((PE_LENGTH > T_LEN) ? PE_LENGTH : T_LEN);
    localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [11:0] F_OPEN = 12'(OPEN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_QLOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [QW-1:0]  r_in_cnt;
    logic [PW-1:0]  r_pass;
    logic [PW-1:0]  w_pass_nxt;
    logic [IW-1:0]  r_i;
    logic [IW-1:0]  w_i_nxt;
    logic [CW-1:0]  r_out_cnt;

    logic [1:0]     r_qbuf [Q_LEN];
    logic [1:0]     r_tbuf [T_LEN];
    logic [11:0]    r_bv   [T_LEN];
    logic [11:0]    r_bf   [T_LEN];

    logic           r_finish;
    logic [11:0]    r_max;
    logic           r_arr_load;
    logic [1:0]     r_arr_s;
    logic           r_arr_valid;
    logic [1:0]     r_arr_t;
    logic [11:0]    r_arr_v_in;
    logic [11:0]    r_arr_f_in;

    logic           w_store;
    logic           w_capture;
    logic           w_last_out;
    logic           w_pass_last;
    logic           w_next_pass;
    logic [QW-1:0]  w_q_idx;
    logic [TW-1:0]  w_t_idx;
    logic [11:0]    w_best;

    assign finish     = r_finish;
    assign max        = r_max;
    assign arr_load   = r_arr_load;
    assign arr_s      = r_arr_s;
    assign arr_valid  = r_arr_valid;
    assign arr_t      = r_arr_t;
    assign arr_v_in   = r_arr_v_in;
    assign arr_f_in   = r_arr_f_in;
    assign arr_max_in = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_i is the index of the item currently on the array bus; outputs are
    // registered from the next-state decode so they line up with r_state.
    always_comb begin
        w_store     = valid && ((r_state == S_IDLE) || (r_state == S_LOAD));
        w_capture   = arr_valid_out && ((r_state == S_STREAM) || (r_state == S_DRAIN))
                      && (r_out_cnt != CW'(T_LEN));
        w_last_out  = (r_out_cnt == CW'(T_LEN)) || (w_capture && (r_out_cnt == CW'(T_LEN - 1)));
        w_pass_last = (r_pass == PW'(PASSES - 1));

        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (valid) w_next_state = S_LOAD;
            S_LOAD:   if (valid && (r_in_cnt == QW'(Q_LEN - 1))) w_next_state = S_QLOAD;
            S_QLOAD:  if (r_i == IW'(PE_LENGTH - 1)) w_next_state = S_STREAM;
            S_STREAM: if (r_i == IW'(T_LEN - 1)) w_next_state = S_DRAIN;
            S_DRAIN:  if (w_last_out) w_next_state = w_pass_last ? S_DONE : S_QLOAD;
            S_DONE:   w_next_state = S_DONE;
            default:  w_next_state = S_IDLE;
        endcase

        w_next_pass = (r_state == S_DRAIN) && (w_next_state == S_QLOAD);
        w_i_nxt     = (w_next_state == r_state) ? r_i + 1'b1 : '0;
        w_pass_nxt  = w_next_pass ? r_pass + 1'b1 : r_pass;
        w_q_idx     = QW'(w_pass_nxt) * QW'(PE_LENGTH) + QW'(w_i_nxt);
        w_t_idx     = TW'(w_i_nxt);

        w_best = r_max;
        if (arr_v_out > w_best) w_best = arr_v_out;
        if (arr_max_out > w_best) w_best = arr_max_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_cnt    <= '0;
            r_pass      <= '0;
            r_i         <= '0;
            r_out_cnt   <= '0;
            r_finish    <= 1'b0;
            r_max       <= '0;
            r_arr_load  <= 1'b0;
            r_arr_s     <= '0;
            r_arr_valid <= 1'b0;
            r_arr_t     <= '0;
            r_arr_v_in  <= '0;
            r_arr_f_in  <= '0;
        end else begin
            if (w_store) r_in_cnt <= r_in_cnt + 1'b1;
            r_pass <= w_pass_nxt;
            r_i    <= w_i_nxt;
            if (w_next_pass) begin
                r_out_cnt <= '0;
            end else if (w_capture) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
            if (w_capture) r_max <= w_best;
            if (w_next_state == S_DONE) r_finish <= 1'b1;

            r_arr_load <= (w_next_state == S_QLOAD);
            r_arr_s    <= (w_next_state == S_QLOAD) ? r_qbuf[w_q_idx] : 2'b00;

            // The first pass sees an empty matrix above it; later passes replay the stored column.
            r_arr_valid <= (w_next_state == S_STREAM);
            if (w_next_state == S_STREAM) begin
                r_arr_t    <= r_tbuf[w_t_idx];
                r_arr_v_in <= (r_pass == '0) ? 12'h000 : r_bv[w_t_idx];
                r_arr_f_in <= (r_pass == '0) ? F_OPEN  : r_bf[w_t_idx];
            end else begin
                r_arr_t    <= '0;
                r_arr_v_in <= '0;
                r_arr_f_in <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store && !reset) begin
            r_qbuf[r_in_cnt]     <= data_s;
            r_tbuf[TW'(r_in_cnt)] <= data_t;
        end
        if (w_capture && !reset) begin
            r_bv[r_out_cnt[TW-1:0]] <= arr_v_out;
            r_bf[r_out_cnt[TW-1:0]] <= arr_f_out;
        end
    end

endmodule
